sequence_round_ctrl: RTL and testbench

SEQUENCE_ROUND_CTRL -- requirements
Module: sequence_round_ctrl

---
 rtl/sequencer_pkg.sv | 7 +
 rtl/sequence_round_ctrl_if.sv | 12 +
 rtl/rise_detect.sv | 11 +
 rtl/sequence_round_ctrl.sv | 64 ++++++
 tb/tb_sequence_round_ctrl.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sequencer_pkg.sv
// sequencer_pkg: round state encoding and default game constants shared by the sequencer blocks.
package sequencer_pkg;
    typedef enum logic [2:0] {IDLE, ARMED, CHECK, WIN, LOSE} roundState;
    localparam logic [5:0] DEF_CODE = 6'b100101;
    localparam int DEF_MAX_TRIES = 3;
    localparam int DEF_TIMEOUT = 50_000_000;
endpackage

// File: rtl/sequence_round_ctrl_if.sv
// sequence_round_ctrl_if: player controls and round status between the game and the round controller.
interface sequence_round_ctrl_if;
    logic start;
    logic go;
    logic [5:0] data_in;
    logic busy;
    logic win;
    logic lose;
    logic [1:0] tries_left;
    modport master (output start, go, data_in, input busy, win, lose, tries_left);
    modport slave (input start, go, data_in, output busy, win, lose, tries_left);
endinterface

// File: rtl/rise_detect.sv
// rise_detect: one-cycle pulse on a 0->1 transition of a level input.
module rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic prev;
    always_ff @(posedge clock) prev <= reset ? 1'b0 : in;
    assign pulse = in & ~prev;
endmodule

// File: rtl/sequence_round_ctrl.sv
// sequence_round_ctrl: combination-lock round FSM with limited tries and a cumulative round timer.
module sequence_round_ctrl
    import sequencer_pkg::*;
#(
    parameter logic [5:0] CODE      = DEF_CODE,
    parameter int         MAX_TRIES = DEF_MAX_TRIES,
    parameter int         TIMEOUT   = DEF_TIMEOUT
) (
    input  logic                 clock,
    input  logic                 reset,
    sequence_round_ctrl_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);
    localparam logic [1:0] FULL_TRIES = 2'(MAX_TRIES);
    roundState state, nextState;
    logic [TW-1:0] timer;
    logic [5:0] capture;
    logic [1:0] triesLeft;
    logic goEdge, expired, newRound, miss, busy;
    rise_detect goDetect (.clock(clock), .reset(reset), .in(bus.go), .pulse(goEdge));
    assign expired = timer == LAST_TICK;
    assign busy = state == ARMED || state == CHECK;
    assign bus.busy = busy;
    assign bus.win = state == WIN;
    assign bus.lose = state == LOSE;
    assign bus.tries_left = triesLeft;
    always_comb begin
        nextState = state;
        newRound = 1'b0;
        miss = 1'b0;
        case (state)
            IDLE, WIN, LOSE: begin
                newRound = bus.start;
                nextState = bus.start ? ARMED : state;
            end
            ARMED: nextState = expired ? LOSE : goEdge ? CHECK : ARMED;
            CHECK: begin
                miss = capture != CODE;
                nextState = !miss ? WIN : triesLeft == 2'd1 ? LOSE : ARMED;
            end
            default: nextState = IDLE;
        endcase
    end
    // Timer saturates at the last tick so a late CHECK hands an expired round back to ARMED for LOSE.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            timer <= '0;
            capture <= '0;
            triesLeft <= '0;
        end else begin
            state <= nextState;
            if (newRound) begin
                timer <= '0;
                triesLeft <= FULL_TRIES;
            end else begin
                if (busy && !expired) timer <= timer + TW'(1);
                if (miss) triesLeft <= triesLeft - 2'd1;
            end
            if (state == ARMED && goEdge && !expired) capture <= bus.data_in;
        end
    end
endmodule

// File: tb/tb_sequence_round_ctrl.sv
// tb_sequence_round_ctrl: directed scenarios plus randomized play checked against a round-level model.
module tb_sequence_round_ctrl;
    localparam logic [5:0] CODE = 6'b100101;
    localparam int MAX_TRIES = 3;
    localparam int TIMEOUT = 20;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int nVec = 0;
    int nErr = 0;
    sequence_round_ctrl_if bus ();
    sequence_round_ctrl #(.CODE(CODE), .MAX_TRIES(MAX_TRIES), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .bus(bus)
    );
    always #5 clock = ~clock;
    // Round model: mode 0 idle, 1 playing, 2 won, 3 lost; elapsed counts playing cycles.
    int mMode = 0, mElapsed = 0, mTries = 0;
    bit mPend = 0, mPrevGo = 0;
    logic [5:0] mVal = '0;
    function automatic logic [4:0] obs();
        return {bus.busy, bus.win, bus.lose, bus.tries_left};
    endfunction
    task automatic cycle();
        bit edgeSeen;
        @(posedge clock);
        edgeSeen = bus.go && !mPrevGo;
        if (reset) begin
            mMode = 0; mElapsed = 0; mTries = 0; mPend = 0; mPrevGo = 0;
        end else begin
            mPrevGo = bus.go;
            if (mMode != 1) begin
                if (bus.start) begin mMode = 1; mTries = MAX_TRIES; mElapsed = 0; mPend = 0; end
            end else if (mPend) begin
                mPend = 0;
                mElapsed = (mElapsed + 1 > TIMEOUT - 1) ? TIMEOUT - 1 : mElapsed + 1;
                if (mVal == CODE) mMode = 2;
                else begin
                    mTries--;
                    if (mTries == 0) mMode = 3;
                end
            end else if (mElapsed >= TIMEOUT - 1) mMode = 3;
            else begin
                if (edgeSeen) begin mPend = 1; mVal = bus.data_in; end
                mElapsed++;
            end
        end
        #1;
    endtask
    task automatic doReset();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask
    task automatic test_reset();
        bus.start = 1'b0; bus.go = 1'b0; bus.data_in = '0;
        doReset();
        nVec++; if (obs() !== 5'b00000) begin nErr++; $display("FAIL reset: got busy/win/lose/tries=%b required %b", obs(), 5'b00000); end
        cycle();
        nVec++; if (obs() !== 5'b00000) begin nErr++; $display("FAIL idle_hold: got busy/win/lose/tries=%b required %b", obs(), 5'b00000); end
    endtask
    task automatic test_win();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        nVec++; if (obs() !== 5'b10011) begin nErr++; $display("FAIL start_arm: got busy/win/lose/tries=%b required %b", obs(), 5'b10011); end
        bus.data_in = CODE; bus.go = 1'b0; cycle();
        bus.go = 1'b1; cycle();
        nVec++; if (obs() !== 5'b10011) begin nErr++; $display("FAIL win_n1: got busy/win/lose/tries=%b required %b", obs(), 5'b10011); end
        cycle();
        nVec++; if (obs() !== 5'b01011) begin nErr++; $display("FAIL win_n2: got busy/win/lose/tries=%b required %b", obs(), 5'b01011); end
        bus.go = 1'b0; repeat (3) cycle();
        nVec++; if (obs() !== 5'b01011) begin nErr++; $display("FAIL win_hold: got busy/win/lose/tries=%b required %b", obs(), 5'b01011); end
    endtask
    task automatic test_restart_exhaust();
        logic [4:0] exp;
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        nVec++; if (obs() !== 5'b10011) begin nErr++; $display("FAIL restart: got busy/win/lose/tries=%b required %b", obs(), 5'b10011); end
        bus.data_in = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            bus.go = 1'b0; cycle();
            bus.go = 1'b1; cycle();
            exp = {3'b100, 2'(3 - i)};
            nVec++; if (obs() !== exp) begin nErr++; $display("FAIL exhaust_check%0d: got busy/win/lose/tries=%b required %b", i, obs(), exp); end
            bus.go = 1'b0; cycle();
            exp = (i < 2) ? {3'b100, 2'(2 - i)} : 5'b00100;
            nVec++; if (obs() !== exp) begin nErr++; $display("FAIL exhaust_step%0d: got busy/win/lose/tries=%b required %b", i, obs(), exp); end
        end
        repeat (3) cycle();
        nVec++; if (obs() !== 5'b00100) begin nErr++; $display("FAIL lose_hold: got busy/win/lose/tries=%b required %b", obs(), 5'b00100); end
    endtask
    task automatic test_go_held();
        bus.go = 1'b1;
        doReset();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (TIMEOUT - 1) cycle();
        nVec++; if (obs() !== 5'b10011) begin nErr++; $display("FAIL held_no_submit: got busy/win/lose/tries=%b required %b", obs(), 5'b10011); end
        cycle();
        nVec++; if (obs() !== 5'b00111) begin nErr++; $display("FAIL held_timeout: got busy/win/lose/tries=%b required %b", obs(), 5'b00111); end
        bus.go = 1'b0;
    endtask
    task automatic test_timeout_race();
        doReset();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (TIMEOUT - 1) cycle();
        bus.data_in = CODE; bus.go = 1'b1; cycle();
        nVec++; if (obs() !== 5'b00111) begin nErr++; $display("FAIL race_lose: got busy/win/lose/tries=%b required %b", obs(), 5'b00111); end
        cycle();
        nVec++; if (obs() !== 5'b00111) begin nErr++; $display("FAIL race_hold: got busy/win/lose/tries=%b required %b", obs(), 5'b00111); end
        bus.go = 1'b0;
    endtask
    task automatic test_check_timeout();
        doReset();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        repeat (TIMEOUT - 2) cycle();
        bus.data_in = 6'b000001; bus.go = 1'b1; cycle();
        cycle();
        nVec++; if (obs() !== 5'b10010) begin nErr++; $display("FAIL check_no_timeout: got busy/win/lose/tries=%b required %b", obs(), 5'b10010); end
        cycle();
        nVec++; if (obs() !== 5'b00110) begin nErr++; $display("FAIL post_check_timeout: got busy/win/lose/tries=%b required %b", obs(), 5'b00110); end
        bus.go = 1'b0;
    endtask
    task automatic test_reset_in_check();
        doReset();
        bus.start = 1'b1; cycle(); bus.start = 1'b0;
        bus.data_in = CODE; bus.go = 1'b1; cycle();
        nVec++; if (obs() !== 5'b10011) begin nErr++; $display("FAIL check_entry: got busy/win/lose/tries=%b required %b", obs(), 5'b10011); end
        reset = 1'b1; cycle(); reset = 1'b0;
        nVec++; if (obs() !== 5'b00000) begin nErr++; $display("FAIL reset_check: got busy/win/lose/tries=%b required %b", obs(), 5'b00000); end
        bus.go = 1'b0; cycle();
        nVec++; if (obs() !== 5'b00000) begin nErr++; $display("FAIL reset_check_idle: got busy/win/lose/tries=%b required %b", obs(), 5'b00000); end
    endtask
    task automatic test_random();
        logic [4:0] exp;
        doReset();
        for (int i = 0; i < 3000; i++) begin
            reset = $urandom_range(99) == 0;
            bus.start = $urandom_range(19) == 0;
            bus.go = $urandom_range(2) == 0;
            bus.data_in = $urandom_range(1) ? CODE : 6'($urandom);
            cycle();
            exp = {mMode == 1, mMode == 2, mMode == 3, 2'(mTries)};
            nVec++; if (obs() !== exp) begin nErr++; $display("FAIL random cycle %0d: got busy/win/lose/tries=%b required %b", i, obs(), exp); end
        end
        reset = 1'b0;
    endtask
    initial begin
        test_reset();
        test_win();
        test_restart_exhaust();
        test_go_held();
        test_timeout_race();
        test_check_timeout();
        test_reset_in_check();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
